uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one Uart8 transmitter among NUM_REQ on-chip requesters (sonar ranging, status, debug).
- Grants whole packets: once granted, a requester keeps the UART until it sends a byte tagged last.
- Selects requesters round-robin, drives Uart8 txEn/txStart/in, and sequences each byte from Uart8 txBusy.
- Sits between the sonar front-end producers and the Uart8 tx interface.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8. Localparam ID_W = $clog2(NUM_REQ).
- START_TIMEOUT, 4096: clk cycles allowed between txStart assertion and txBusy rising. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbitration enable; sampled only in IDLE
- reqValid  in  NUM_REQ  per-requester byte valid
- reqData  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- reqLast  in  NUM_REQ  byte is the last byte of its packet
- reqReady  out  NUM_REQ  one-cycle accept pulse; at most one bit set
- grantId  out  ID_W  current owner; valid while packetActive
- packetActive  out  1  a packet is in progress
- txEn  out  1  to Uart8 txEn
- txStart  out  1  to Uart8 txStart
- txByte  out  8  to Uart8 in
- txBusy  in  1  from Uart8 txBusy
- txDone  in  1  from Uart8 txDone; monitored only under TX_START_TIMEOUT_EN
- errTimeout  out  1  sticky start-timeout flag; exists only under TX_START_TIMEOUT_EN

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, rrPtr=0, reqReady=0, grantId=0, packetActive=0, txEn=0, txStart=0, txByte=0, lastFlag=0, errTimeout=0.
- IDLE:
  - Acts only when en=1 and some reqValid bit is set.
  - Picks the first valid index at or after rrPtr, modulo NUM_REQ.
  - Same cycle: pulses reqReady[i]; latches reqData[i] into txByte and reqLast[i] into lastFlag; sets grantId=i and packetActive=1.
  - Next state: START.
- START:
  - txEn=1, txStart=1.
  - Stays until txBusy=1, then txStart=0 and next state is WAIT.
  - txByte is held stable throughout.
- WAIT:
  - txEn=1, txStart=0.
  - On txBusy=0 (byte fully shifted), goes to NEXT.
- NEXT, if lastFlag=1:
  - rrPtr=(grantId+1) mod NUM_REQ, packetActive=0, txEn=0.
  - Next state: IDLE.
  - The new IDLE may grant no earlier than the following cycle, so there is at least one idle cycle between packets.
- NEXT, if lastFlag=0:
  - Waits, with txEn=1 held, for reqValid[grantId].
  - Then pulses reqReady[grantId], latches the byte and last flag, and goes to START.
  - Other requesters are ignored; the grant is held indefinitely while the owner stalls.
- Latency: the byte is accepted in cycle 0 and txStart rises in cycle 1.
- Uart8 handshake: reqData/reqLast must be stable while reqValid=1. The Uart8 must raise txBusy while txStart is held.
- en=0 mid-packet does not abort; the packet completes.
- reqValid from the owner during START/WAIT is ignored; no reqReady until NEXT.
- Only the owner's reqReady ever pulses. reqReady is never high in two consecutive cycles.
- rrPtr wrap: NUM_REQ-1 advances to 0.
- Reset mid-byte: txEn drops immediately, which aborts the Uart8 frame. The partial byte is lost and not retried.

Optional Feature:
- Macro: TX_START_TIMEOUT_EN.
- When defined:
  - A 13-bit-or-wider counter runs in START.
  - If txBusy stays 0 for START_TIMEOUT cycles: set errTimeout (sticky until reset), drop txStart and txEn, and go to IDLE.
  - rrPtr advances past the owner; the remaining packet bytes are not accepted.
  - If txDone=1 with txBusy=0 in START, that byte also counts as sent and the FSM goes to NEXT.
- When undefined: no counter and no errTimeout port; START waits indefinitely.

Decomposition:
- Shared package uart_ctrl_pkg:
  - state encoding: IDLE=0, START=1, WAIT=2, NEXT=3
  - BYTE_W=8
  - default START_TIMEOUT
- One sub-module, rr_pick:
  - combinational first-set-at-or-after-pointer search over NUM_REQ
  - outputs found and index
  - instantiated once in uart_tx_arbiter.

Test Plan:
1. Req0 valid with 0x45, last=1 → reqReady[0] pulse, txByte=0x45, txStart high until txBusy; then packetActive falls and rrPtr=1.
2. Req0 and req2 both valid with single-byte packets, rrPtr=0 → req0 sent first, then req2; rrPtr ends at 3.
3. Req1 sends a 3-byte packet 0xA1,0xA2,0xA3 while req0 is continuously valid → all three req1 bytes go out back-to-back before req0's first reqReady.
4. Grant to req3 (NUM_REQ=4), single byte → rrPtr wraps to 0; next simultaneous req0/req3 grants req0.
5. Assert rst_n=0 during WAIT of the 2nd byte of a packet → txEn=0 and state IDLE in the same cycle; all outputs at reset values.
6. TX_START_TIMEOUT_EN with START_TIMEOUT=16 and txBusy tied low → errTimeout rises 16 cycles after txStart; FSM returns to IDLE; the next requester is granted.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// byte width and the default start-timeout length.
package uart_ctrl_pkg;

  localparam int BYTE_W                = 8;
  localparam int START_TIMEOUT_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    NEXT  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and Uart8-side signals of the transmit arbiter.
// master: the arbiter. slave: requesters plus the Uart8 transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_ctrl_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        reqValid;
  logic [BYTE_W*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]        reqLast;
  logic [NUM_REQ-1:0]        reqReady;
  logic [ID_W-1:0]           grantId;
  logic                      packetActive;
  logic                      txEn;
  logic                      txStart;
  logic [BYTE_W-1:0]         txByte;
  logic                      txBusy;
  logic                      txDone;

  modport master (
    input  reqValid, reqData, reqLast, txBusy, txDone,
    output reqReady, grantId, packetActive, txEn, txStart, txByte
  );

  modport slave (
    output reqValid, reqData, reqLast, txBusy, txDone,
    input  reqReady, grantId, packetActive, txEn, txStart, txByte
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set request bit at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_idx
);

  // Search the upper segment [ptr..N-1] first, then fall back to [0..N-1].
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (!o_found && i_req[c] && (ID_W'(c) >= i_ptr)) begin
        o_found = 1'b1;
        o_idx   = ID_W'(c);
      end
    end
    for (int c = 0; c < NUM_REQ; c++) begin
      if (!o_found && i_req[c]) begin
        o_found = 1'b1;
        o_idx   = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one Uart8 transmitter among
// NUM_REQ requesters. Optional macro TX_START_TIMEOUT_EN adds a start
// timeout (errTimeout port, txDone monitoring in START).
//
// state | meaning
// IDLE  | no packet; grant first valid requester at/after rrPtr
// START | txStart held until the Uart8 raises txBusy
// WAIT  | byte shifting; leave when txBusy falls
// NEXT  | end packet if lastFlag, else wait for the owner's next byte
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  uart_tx_arbiter_if.master bus
`ifdef TX_START_TIMEOUT_EN
  ,
  output logic              errTimeout
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic                r_pkt_active;
  logic                r_last_flag;
  logic [BYTE_W-1:0]   r_tx_byte;
  logic                r_run;

  logic                w_found;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_accept;
  logic [ID_W-1:0]     w_acc_idx;
  logic [BYTE_W-1:0]   w_acc_byte;
  logic                w_acc_last;
  logic                w_end_pkt;
  logic                w_tmo_hit;
  logic                w_tx_en;
  logic                w_tx_start;
  logic [NUM_REQ-1:0]  w_req_ready;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req   (bus.reqValid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

`ifdef TX_START_TIMEOUT_EN
  localparam int TMO_W = ($clog2(START_TIMEOUT) + 1 > 13) ? $clog2(START_TIMEOUT) + 1 : 13;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err_timeout;

  // Start-timeout down-counter: loaded on entry to START, terminal count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_state_nxt == START && r_state != START) begin
        r_tmo_cnt <= TMO_W'(START_TIMEOUT - 1);
      end else if (r_state == START && r_tmo_cnt != '0) begin
        r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
      end
      if (w_tmo_hit) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign errTimeout = r_err_timeout;
`else
  localparam int unused_start_timeout = START_TIMEOUT;
  logic w_unused_tx_done;
  assign w_unused_tx_done = bus.txDone;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, byte acceptance and Uart8 strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_acc_idx   = r_grant_id;
    w_end_pkt   = 1'b0;
    w_tmo_hit   = 1'b0;
    w_tx_en     = 1'b0;
    w_tx_start  = 1'b0;
    case (r_state)
      IDLE: begin
        // r_run keeps reqReady quiet while reset is asserted.
        if (r_run && en && w_found) begin
          w_accept    = 1'b1;
          w_acc_idx   = w_pick_idx;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx_en    = 1'b1;
        w_tx_start = 1'b1;
        if (bus.txBusy) begin
          w_state_nxt = WAIT;
`ifdef TX_START_TIMEOUT_EN
        end else if (bus.txDone) begin
          w_state_nxt = NEXT;
        end else if (r_tmo_cnt == '0) begin
          w_tmo_hit   = 1'b1;
          w_end_pkt   = 1'b1;
          w_state_nxt = IDLE;
`endif
        end
      end
      WAIT: begin
        w_tx_en = 1'b1;
        if (!bus.txBusy) begin
          w_state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (r_last_flag) begin
          w_end_pkt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tx_en = 1'b1;
          if (bus.reqValid[r_grant_id]) begin
            w_accept    = 1'b1;
            w_state_nxt = START;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the accepted requester's byte and last flag; decode its ready pulse.
  always_comb begin
    w_acc_byte  = '0;
    w_acc_last  = 1'b0;
    w_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_acc_idx == ID_W'(i)) begin
        w_acc_byte     = bus.reqData[i*BYTE_W +: BYTE_W];
        w_acc_last     = bus.reqLast[i];
        w_req_ready[i] = w_accept;
      end
    end
  end

  // Grant, packet and round-robin pointer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_pkt_active <= 1'b0;
      r_last_flag  <= 1'b0;
      r_tx_byte    <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_tx_byte    <= w_acc_byte;
        r_last_flag  <= w_acc_last;
        r_grant_id   <= w_acc_idx;
        r_pkt_active <= 1'b1;
      end
      if (w_end_pkt) begin
        r_pkt_active <= 1'b0;
        r_rr_ptr     <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
      end
    end
  end

  assign bus.reqReady     = w_req_ready;
  assign bus.grantId      = r_grant_id;
  assign bus.packetActive = r_pkt_active;
  assign bus.txEn         = w_tx_en;
  assign bus.txStart      = w_tx_start;
  assign bus.txByte       = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple Uart8 model, a requester
// driver fed from a pending-byte queue, and a scoreboard of expected
// (owner, byte) pairs checked when the Uart8 model starts each byte.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         last;
  } pend_t;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic en;
`ifdef TX_START_TIMEOUT_EN
  logic err_timeout;
`endif

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NREQ)
`ifdef TX_START_TIMEOUT_EN
    ,
    .START_TIMEOUT (16)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
`ifdef TX_START_TIMEOUT_EN
    ,
    .errTimeout (err_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  pend_t pend[$];
  exp_t  exp_q[$];
  int    acc_cnt[NREQ];
  bit    u_enable = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_req(input int id, input logic [7:0] data, input bit last);
    pend_t p;
    p.id = id; p.data = data; p.last = last;
    pend.push_back(p);
  endtask

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id = id; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && pend.size() == 0 &&
          bus.packetActive === 1'b0 && bus.txEn === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  // Uart8 model: txBusy rises 3 cycles after txStart, stays 6 cycles, then txDone pulses.
  int u_phase;
  int u_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.txBusy <= 1'b0;
      bus.txDone <= 1'b0;
      u_phase    <= 0;
      u_cnt      <= 0;
    end else if (!bus.txEn || !u_enable) begin
      bus.txBusy <= 1'b0;
      bus.txDone <= 1'b0;
      u_phase    <= 0;
    end else begin
      case (u_phase)
        0: begin
          bus.txDone <= 1'b0;
          if (bus.txStart) begin
            u_cnt   <= 2;
            u_phase <= 1;
          end
        end
        1: begin
          if (u_cnt == 0) begin
            bus.txBusy <= 1'b1;
            u_cnt      <= 5;
            u_phase    <= 2;
          end else u_cnt <= u_cnt - 1;
        end
        default: begin
          if (u_cnt == 0) begin
            bus.txBusy <= 1'b0;
            bus.txDone <= 1'b1;
            u_phase    <= 0;
          end else u_cnt <= u_cnt - 1;
        end
      endcase
    end
  end

  // Requester driver: each requester presents its oldest pending byte until accepted.
  initial begin
    logic [NREQ-1:0]   seen;
    logic [NREQ-1:0]   v;
    logic [8*NREQ-1:0] d;
    logic [NREQ-1:0]   l;
    bus.reqValid = '0;
    bus.reqData  = '0;
    bus.reqLast  = '0;
    forever begin
      @(negedge clk);
      seen = bus.reqReady;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (seen[i] === 1'b1) begin
          for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == i) begin
              pend.delete(k);
              acc_cnt[i]++;
              break;
            end
          end
        end
      end
      v = '0; d = '0; l = '0;
      for (int i = 0; i < NREQ; i++) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].id == i) begin
            v[i]         = 1'b1;
            d[i*8 +: 8]  = pend[k].data;
            l[i]         = pend[k].last;
            break;
          end
        end
      end
      bus.reqValid = v;
      bus.reqData  = d;
      bus.reqLast  = l;
    end
  end

  // Scoreboard and reqReady protocol monitor.
  logic            busy_prev = 1'b0;
  logic [NREQ-1:0] rr_prev   = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.txBusy === 1'b1 && busy_prev === 1'b0) begin
        chk("sb_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("txByte", 32'(bus.txByte), 32'(e.data));
          chk("grantId", 32'(bus.grantId), 32'(e.id));
          chk("txStart_until_busy", 32'(bus.txStart), 32'd1);
        end
      end
      if (bus.reqReady !== '0) begin
        chk("reqReady_onehot", 32'($onehot(bus.reqReady)), 32'd1);
        chk("reqReady_not_consecutive", 32'(rr_prev), 32'd0);
        if (bus.packetActive === 1'b1)
          chk("reqReady_owner_only", 32'(bus.reqReady), 32'(1) << bus.grantId);
      end
    end
    busy_prev = bus.txBusy;
    rr_prev   = bus.reqReady;
  end

  initial begin
    bit found;
    int n;
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_reqReady", 32'(bus.reqReady), 32'd0);
    chk("rst_packetActive", 32'(bus.packetActive), 32'd0);
    chk("rst_txEn", 32'(bus.txEn), 32'd0);
    chk("rst_txStart", 32'(bus.txStart), 32'd0);
    chk("rst_txByte", 32'(bus.txByte), 32'd0);
    chk("rst_grantId", 32'(bus.grantId), 32'd0);
`ifdef TX_START_TIMEOUT_EN
    chk("rst_errTimeout", 32'(err_timeout), 32'd0);
`endif
    rst_n = 1'b1;

    // Single-byte packet from req0.
    push_req(0, 8'h45, 1'b1); push_exp(0, 8'h45);
    wait_idle("t1");
    chk("t1_req0_accepts", 32'(acc_cnt[0]), 32'd1);

    // rrPtr now 1: req1 beats req0.
    push_req(0, 8'h10, 1'b1); push_req(1, 8'h11, 1'b1);
    push_exp(1, 8'h11); push_exp(0, 8'h10);
    wait_idle("t1b");

    // Reset returns rrPtr to 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    push_req(0, 8'h20, 1'b1); push_req(2, 8'h22, 1'b1);
    push_exp(0, 8'h20); push_exp(2, 8'h22);
    wait_idle("t2");

    // rrPtr=3: req3 before req1, then wrap.
    push_req(1, 8'h31, 1'b1); push_req(3, 8'h33, 1'b1);
    push_exp(3, 8'h33); push_exp(1, 8'h31);
    wait_idle("t4a");

    push_req(3, 8'h35, 1'b1); push_exp(3, 8'h35);
    wait_idle("t4b");
    push_req(0, 8'h40, 1'b1); push_req(3, 8'h43, 1'b1);
    push_exp(0, 8'h40); push_exp(3, 8'h43);
    wait_idle("t4c");

    // Multi-byte packet from req1 holds the grant while req0 waits.
    push_req(1, 8'hA1, 1'b0); push_req(1, 8'hA2, 1'b0); push_req(1, 8'hA3, 1'b1);
    push_exp(1, 8'hA1); push_exp(1, 8'hA2); push_exp(1, 8'hA3); push_exp(0, 8'h50);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.packetActive === 1'b1) begin found = 1'b1; break; end
    end
    chk("t3_granted", 32'(found), 32'd1);
    push_req(0, 8'h50, 1'b1);
    wait_idle("t3");
    chk("t3_req1_accepts", 32'(acc_cnt[1]), 32'd5);

    // Reset during WAIT of the second byte.
    push_req(2, 8'h61, 1'b0); push_req(2, 8'h62, 1'b1);
    push_exp(2, 8'h61); push_exp(2, 8'h62);
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (bus.txBusy === 1'b1 && bus.txStart === 1'b0 && bus.txByte === 8'h62) begin
        found = 1'b1; break;
      end
    end
    chk("t5_wait_2nd", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_txEn", 32'(bus.txEn), 32'd0);
    chk("t5_txStart", 32'(bus.txStart), 32'd0);
    chk("t5_reqReady", 32'(bus.reqReady), 32'd0);
    chk("t5_packetActive", 32'(bus.packetActive), 32'd0);
    chk("t5_grantId", 32'(bus.grantId), 32'd0);
    chk("t5_txByte", 32'(bus.txByte), 32'd0);
    chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_req(1, 8'h71, 1'b1); push_req(0, 8'h70, 1'b1);
    push_exp(0, 8'h70); push_exp(1, 8'h71);
    wait_idle("t5_after");

`ifdef TX_START_TIMEOUT_EN
    // Uart8 silent: START times out after 16 cycles, next requester granted.
    u_enable = 1'b0;
    push_req(0, 8'h80, 1'b1); push_req(1, 8'h81, 1'b1);
    push_exp(1, 8'h81);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.txStart === 1'b1) begin found = 1'b1; break; end
    end
    chk("t6_start_seen", 32'(found), 32'd1);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n++;
      if (err_timeout === 1'b1) break;
    end
    chk("t6_tmo_cycles", 32'(n), 32'd16);
    chk("t6_txStart_dropped", 32'(bus.txStart), 32'd0);
    chk("t6_txEn_dropped", 32'(bus.txEn), 32'd0);
    u_enable = 1'b1;
    wait_idle("t6");
    chk("t6_err_sticky", 32'(err_timeout), 32'd1);
`endif

    chk("sb_empty_end", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
